hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Pipeline hazard controller that sits beside the forwarding unit, between decode and execute.
- Detects hazards forwarding cannot resolve: load-use dependencies, multi-cycle vector operations occupying execute, taken branches resolved in execute.
- Drives stall and flush signals to the fetch/decode, decode/execute and execute/memory pipeline registers.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- VEC_LATENCY, 4, total execute-stage cycles of a vector operation; legal range 2..15.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_decode  input  5  source register 1 of the instruction in decode.
- rs2_decode  input  5  source register 2 of the instruction in decode.
- uses_rs2_decode  input  1  decode instruction reads rs2; this includes the store data operand.
- rd_execute  input  5  destination register of the instruction in execute.
- mem_read_execute  input  1  the instruction in execute is a load.
- wre_execute  input  1  scalar register-file write enable in execute.
- wre_vector_execute  input  1  vector register-file write enable in execute.
- vector_start_execute  input  1  a multi-cycle vector operation entered execute this cycle.
- branch_taken_execute  input  1  branch or jump resolved taken in execute.
- stall_fetch  output  1  hold the PC and the fetch/decode register.
- stall_decode  output  1  hold the decode/execute register.
- stall_execute  output  1  hold the execute stage and its inputs.
- flush_decode  output  1  clear the fetch/decode register to a NOP.
- flush_execute  output  1  clear the decode/execute register to a NOP (bubble).
- bubble_memory  output  1  insert a NOP into the execute/memory register.
- vector_busy  output  1  vector operation in progress.
- stall_count  output  CNT_WIDTH  number of cycles with stall_fetch asserted.

Behaviour:
Reset and encoding
- Reset is asynchronous, active-low. While rst_n is low: state IDLE, vec_cnt 0, stall_count 0, all 1-bit outputs 0.
- State encoding is IDLE, VEC_BUSY.
- vec_cnt is 4 bits.

State transitions
- IDLE -> VEC_BUSY when vector_start_execute=1. vec_cnt loads VEC_LATENCY-1 on that edge.
- VEC_BUSY: vec_cnt decrements each cycle. Return to IDLE on the edge where vec_cnt==1, so execute is occupied for exactly VEC_LATENCY cycles including the start cycle.
- vector_start_execute is ignored while in VEC_BUSY.

Output priority (highest first; outputs are combinational from state and inputs)
1. Vector busy: active when state==VEC_BUSY, or when IDLE with vector_start_execute=1.
   - Asserts stall_fetch, stall_decode, stall_execute, bubble_memory, vector_busy.
   - All flushes are 0.
2. Branch taken: active when branch_taken_execute=1 and not vector busy.
   - Asserts flush_decode and flush_execute for that cycle. No stall.
   - A branch raised during vector busy is ignored here; execute re-presents it after the vector op completes.
3. Load-use: active when mem_read_execute=1 and (wre_execute or wre_vector_execute) and rd_execute!=0, and either rd_execute==rs1_decode or (uses_rs2_decode and rd_execute==rs2_decode).
   - Asserts stall_fetch, stall_decode, flush_execute for exactly one cycle.
   - The next cycle the load is in memory and the forwarding unit supplies the data.
4. Otherwise all 1-bit outputs are 0.

Register x0 and counter
- A load targeting x0 never stalls.
- rs1 and rs2 both matching produce a single stall, not two.
- stall_count increments on every clock where stall_fetch=1 and saturates at all-ones with no wrap.

Reset mid-operation
- Aborts VEC_BUSY immediately.
- Outputs deassert asynchronously; no pending stall survives reset.

Decomposition:
- Add to the shared cpu package: typedef enum logic [0:0] hazard_state_t {IDLE, VEC_BUSY}; localparam REG_ZERO = 5'd0; localparam VEC_LATENCY_DEFAULT = 4.
- One sub-module is natural: sat_counter (parameterised width, inc, async active-low reset), used for stall_count and reusable for other performance counters.
- The load-use compare stays inline.

Test Plan:
- Load-use: load with rd_execute=5, mem_read_execute=1, wre_execute=1, rs1_decode=5 -> stall_fetch, stall_decode, flush_execute high for exactly 1 cycle; stall_count 0->1.
- Load into x0: rd_execute=0, rs1_decode=0, mem_read_execute=1 -> no stall, no flush; stall_count unchanged.
- Vector op, VEC_LATENCY=4: pulse vector_start_execute -> stall_fetch, stall_execute, vector_busy high for 4 consecutive cycles, then low; stall_count +4.
- Branch during vector busy: branch_taken_execute=1 on the 2nd busy cycle -> no flush; flush_decode and flush_execute assert only once the branch is presented after busy ends.
- Simultaneous branch and load-use hazard in IDLE -> flush_decode=1, flush_execute=1, stall_fetch=0.
- Reset mid-vector: assert rst_n=0 on the 2nd busy cycle -> all outputs 0 asynchronously, stall_count 0; after release, state is IDLE.
- Saturation, CNT_WIDTH=4: hold a hazard for 20 cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_unit_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        VEC_BUSY = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         VEC_LATENCY_DEFAULT = 4;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_depends(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter for performance monitoring; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller between decode and execute: load-use, vector-occupancy
// and taken-branch handling, plus a stall-cycle performance counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int VEC_LATENCY = VEC_LATENCY_DEFAULT,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_decode,
    input  logic [4:0]           rs2_decode,
    input  logic                 uses_rs2_decode,
    input  logic [4:0]           rd_execute,
    input  logic                 mem_read_execute,
    input  logic                 wre_execute,
    input  logic                 wre_vector_execute,
    input  logic                 vector_start_execute,
    input  logic                 branch_taken_execute,
    output logic                 stall_fetch,
    output logic                 stall_decode,
    output logic                 stall_execute,
    output logic                 flush_decode,
    output logic                 flush_execute,
    output logic                 bubble_memory,
    output logic                 vector_busy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [3:0] VEC_LOAD = 4'(VEC_LATENCY - 1);

    hazard_state_t state_q;
    logic [3:0]    vec_cnt_q;
    logic          vec_busy_s;
    logic          load_use_s;

    // Vector occupancy FSM; the start cycle counts as the first busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vector_start_execute) begin
                        state_q   <= VEC_BUSY;
                        vec_cnt_q <= VEC_LOAD;
                    end else begin
                        state_q   <= IDLE;
                        vec_cnt_q <= vec_cnt_q;
                    end
                end
                VEC_BUSY: begin
                    vec_cnt_q <= vec_cnt_q - 4'd1;
                    if (vec_cnt_q == 4'd1) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= VEC_BUSY;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    vec_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign vec_busy_s = (state_q == VEC_BUSY) || ((state_q == IDLE) && vector_start_execute);

    assign load_use_s = mem_read_execute && (wre_execute || wre_vector_execute) &&
                        (reg_depends(rd_execute, rs1_decode) ||
                         (uses_rs2_decode && reg_depends(rd_execute, rs2_decode)));

    // Prioritised stall/flush decode; forced low while reset is held.
    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        bubble_memory = 1'b0;
        vector_busy   = 1'b0;
        if (!rst_n) begin
            stall_fetch = 1'b0;
        end else if (vec_busy_s) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            bubble_memory = 1'b1;
            vector_busy   = 1'b1;
        end else if (branch_taken_execute) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
        end else if (load_use_s) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
        end else begin
            stall_fetch = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_fetch),
        .count_o (stall_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of single-cycle vectors plus
// hand-written vector-op, branch-during-busy, reset and saturation sequences.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        u2, mr, wre, wrev, vs, br;

    logic        sf, sd, se, fd, fe, bm, vb;
    logic [31:0] cnt;
    logic        s_sf, s_sd, s_se, s_fd, s_fe, s_bm, s_vb;
    logic [3:0]  s_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [3:0]  exp_s_cnt = 4'd0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       wre;
        logic       wrev;
        logic       br;
        logic [6:0] exp;  // {sf, sd, se, fd, fe, bm, vb}
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    hazard_unit #(.VEC_LATENCY(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_decode(rs1), .rs2_decode(rs2), .uses_rs2_decode(u2),
        .rd_execute(rd), .mem_read_execute(mr), .wre_execute(wre),
        .wre_vector_execute(wrev), .vector_start_execute(vs),
        .branch_taken_execute(br),
        .stall_fetch(sf), .stall_decode(sd), .stall_execute(se),
        .flush_decode(fd), .flush_execute(fe), .bubble_memory(bm),
        .vector_busy(vb), .stall_count(cnt)
    );

    hazard_unit #(.VEC_LATENCY(4), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .rs1_decode(rs1), .rs2_decode(rs2), .uses_rs2_decode(u2),
        .rd_execute(rd), .mem_read_execute(mr), .wre_execute(wre),
        .wre_vector_execute(wrev), .vector_start_execute(vs),
        .branch_taken_execute(br),
        .stall_fetch(s_sf), .stall_decode(s_sd), .stall_execute(s_se),
        .flush_decode(s_fd), .flush_execute(s_fe), .bubble_memory(s_bm),
        .vector_busy(s_vb), .stall_count(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic a_u2,
                         input logic [4:0] a_rd, input logic a_mr, input logic a_wre,
                         input logic a_wrev, input logic a_vs, input logic a_br);
        rs1 = a1; rs2 = a2; u2 = a_u2; rd = a_rd;
        mr = a_mr; wre = a_wre; wrev = a_wrev; vs = a_vs; br = a_br;
    endtask

    // Called at posedge+1 with inputs set: check outputs mid-cycle, then counters after the edge.
    task automatic cyc(input string name, input logic [6:0] exp7);
        #3;
        check({name, "_outs"}, {25'd0, sf, sd, se, fd, fe, bm, vb}, {25'd0, exp7});
        check({name, "_small_outs"}, {25'd0, s_sf, s_sd, s_se, s_fd, s_fe, s_bm, s_vb}, {25'd0, exp7});
        @(posedge clk);
        #1;
        if (exp7[6]) begin
            exp_cnt = exp_cnt + 32'd1;
            if (exp_s_cnt != 4'hF) exp_s_cnt = exp_s_cnt + 4'd1;
        end
        check({name, "_cnt"}, cnt, exp_cnt);
        check({name, "_small_cnt"}, {28'd0, s_cnt}, {28'd0, exp_s_cnt});
    endtask

    initial begin
        tbl[0]  = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 7'b1100100};
        tbl[1]  = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000};
        tbl[2]  = '{5'd3,  5'd7,  1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 7'b1100100};
        tbl[3]  = '{5'd3,  5'd7,  1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000};
        tbl[4]  = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
        tbl[5]  = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        tbl[6]  = '{5'd9,  5'd0,  1'b0, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 7'b1100100};
        tbl[7]  = '{5'd12, 5'd12, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1100100};
        tbl[8]  = '{5'd1,  5'd2,  1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 1'b1, 7'b0001100};
        tbl[9]  = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 7'b0001100};
        tbl[10] = '{5'd6,  5'd0,  1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000};
        tbl[11] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};

        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_outs", {25'd0, sf, sd, se, fd, fe, bm, vb}, 32'd0);
        check("reset_cnt", cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle vectors from IDLE
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].mr,
                  tbl[i].wre, tbl[i].wrev, 1'b0, tbl[i].br);
            cyc($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // Vector op occupies execute for exactly 4 cycles
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("vec_c1", 7'b1110011);
        vs = 1'b0;
        cyc("vec_c2", 7'b1110011);
        cyc("vec_c3", 7'b1110011);
        cyc("vec_c4", 7'b1110011);
        cyc("vec_done", 7'b0000000);

        // Branch held during busy is ignored until busy ends; a re-start while busy is ignored
        vs = 1'b1;
        cyc("vbr_c1", 7'b1110011);
        vs = 1'b0; br = 1'b1;
        cyc("vbr_c2", 7'b1110011);
        vs = 1'b1;
        cyc("vbr_c3", 7'b1110011);
        vs = 1'b0;
        cyc("vbr_c4", 7'b1110011);
        cyc("vbr_flush", 7'b0001100);
        br = 1'b0;
        cyc("vbr_idle", 7'b0000000);

        // Reset asserted on the 2nd busy cycle
        vs = 1'b1;
        cyc("rst_c1", 7'b1110011);
        vs = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {25'd0, sf, sd, se, fd, fe, bm, vb}, 32'd0);
        check("rst_async_cnt", cnt, 32'd0);
        check("rst_async_small_cnt", {28'd0, s_cnt}, 32'd0);
        exp_cnt   = 32'd0;
        exp_s_cnt = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_idle", 7'b0000000);

        // Saturation of the 4-bit counter under a held load-use hazard
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("sat%0d", i), 7'b1100100);
        end
        check("sat_hold", {28'd0, s_cnt}, 32'd15);
        check("sat_wide_cnt", cnt, 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
